pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl_pkg.sv | 51 +++++
 rtl/pipe_stall_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
//
// Shared pipeline definitions used by the stall/flush controller:
//   - mode_e / MODE_W   : pipeline mode encoding (RUN, BUBBLE, FREEZE), 2 bits
//   - BUB_CNT_W         : width of the consecutive-bubble counter
//   - STALL_CNT_W       : width of the non-RUN cycle counter
//   - pipe_ctrl_t       : bundle of per-stage write enables and flushes
//   - decode_mode()     : hazard priority decode (freeze beats bubble)
// -----------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

   localparam int MODE_W      = 2;
   localparam int BUB_CNT_W   = 2;
   localparam int STALL_CNT_W = 32;

   typedef enum logic [MODE_W-1:0] {
      MODE_RUN    = 2'd0,
      MODE_BUBBLE = 2'd1,
      MODE_FREEZE = 2'd2
   } mode_e;

   // All-ones value of the bubble counter; it saturates here.
   localparam logic [BUB_CNT_W-1:0] BUB_CNT_SAT = '1;

   typedef struct packed {
      logic pc_wr;
      logic ifid_wr;
      logic ifid_flush;
      logic idex_wr;
      logic idex_flush;
      logic exmem_wr;
      logic memwb_flush;
   } pipe_ctrl_t;

   // A memory wait freezes everything, so it must win over any ID hazard:
   // inserting a bubble while EX/MEM is frozen would drop the instruction in EX.
   function automatic mode_e decode_mode(input logic mem_wait,
                                         input logic branch_bubble,
                                         input logic load_use);
      mode_e m;
      if (mem_wait)
         m = MODE_FREEZE;
      else if (branch_bubble || load_use)
         m = MODE_BUBBLE;
      else
         m = MODE_RUN;
      return m;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Central stall/flush controller for a classic 5-stage pipeline. Each cycle the
// live hazard inputs are decoded into a mode and the per-stage enables/flushes
// are driven combinationally from that mode. A small amount of state tracks a
// redirect that arrived while the pipe was frozen, the number of stall cycles,
// and runs of consecutive bubbles.
//
// Parameters
//   DELAY_SLOT  1 keeps the instruction after a taken branch (no IF/ID flush)
//   MAX_BUBBLE  longest legal run of consecutive bubble cycles
//
// Ports
//   clk, rst         clock (rising edge) and synchronous active-high reset
//   branch_bubble    branch in ID waits on a load in EX
//   load_use         ALU op in ID waits on a load in EX
//   id_redirect      taken branch/jump resolved in ID this cycle
//   mem_wait         data memory not ready, freeze whole pipe
//   pc_wr, ifid_wr, idex_wr, exmem_wr   stage write enables
//   ifid_flush, idex_flush, memwb_flush stage flushes (bubble insertion)
//   mode             decoded mode of the previous cycle (0 RUN,1 BUBBLE,2 FREEZE)
//   stall_cnt        wrapping count of non-RUN cycles
//   hazard_err       sticky flag: a bubble run exceeded MAX_BUBBLE
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int DELAY_SLOT = 0,
   parameter int MAX_BUBBLE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_bubble,
   input  logic        load_use,
   input  logic        id_redirect,
   input  logic        mem_wait,
   output logic        pc_wr,
   output logic        ifid_wr,
   output logic        ifid_flush,
   output logic        idex_wr,
   output logic        idex_flush,
   output logic        exmem_wr,
   output logic        memwb_flush,
   output logic [1:0]  mode,
   output logic [31:0] stall_cnt,
   output logic        hazard_err
);

   localparam logic FLUSH_ON_REDIRECT = (DELAY_SLOT == 0);

   // ---------------------------------------------------------------- state
   mode_e                  mode_q, mode_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [BUB_CNT_W-1:0]   bub_run_q, bub_run_d;
   logic                   redirect_pend_q, redirect_pend_d;
   logic                   hazard_err_q, hazard_err_d;

   // ---------------------------------------------------------------- comb
   mode_e              mode_cur;
   pipe_ctrl_t         ctrl;
   logic [BUB_CNT_W:0] bub_run_inc;   // one bit wider so overflow is visible
   logic               bub_overrun;

   always_comb begin
      mode_cur = decode_mode(mem_wait, branch_bubble, load_use);

      // RUN values are the default; the other modes override.
      ctrl.pc_wr       = 1'b1;
      ctrl.ifid_wr     = 1'b1;
      ctrl.ifid_flush  = 1'b0;
      ctrl.idex_wr     = 1'b1;
      ctrl.idex_flush  = 1'b0;
      ctrl.exmem_wr    = 1'b1;
      ctrl.memwb_flush = 1'b0;

      redirect_pend_d = redirect_pend_q;
      bub_run_d       = bub_run_q;
      bub_run_inc     = {1'b0, bub_run_q} + 1'b1;
      bub_overrun     = 1'b0;

      unique case (mode_cur)
         MODE_FREEZE: begin
            // Hold IF..MEM in place; MEM/WB gets a bubble so WB does not
            // retire the same instruction twice.
            ctrl.pc_wr       = 1'b0;
            ctrl.ifid_wr     = 1'b0;
            ctrl.idex_wr     = 1'b0;
            ctrl.exmem_wr    = 1'b0;
            ctrl.memwb_flush = 1'b1;
            // ID cannot act on a redirect while frozen; remember it so the
            // wrong-path fetch is squashed once the pipe moves again.
            if (id_redirect)
               redirect_pend_d = 1'b1;
         end
         MODE_BUBBLE: begin
            // Hold PC and IF/ID, push a bubble into EX. A redirect seen here
            // is ignored: ID re-presents the branch after the bubble.
            ctrl.pc_wr      = 1'b0;
            ctrl.ifid_wr    = 1'b0;
            ctrl.idex_flush = 1'b1;
            if (int'(bub_run_inc) > MAX_BUBBLE)
               bub_overrun = 1'b1;
            bub_run_d = (bub_run_q == BUB_CNT_SAT) ? bub_run_q
                                                   : bub_run_inc[BUB_CNT_W-1:0];
         end
         default: begin
            ctrl.ifid_flush = FLUSH_ON_REDIRECT && (id_redirect || redirect_pend_q);
            redirect_pend_d = 1'b0;
            bub_run_d       = '0;
         end
      endcase

      mode_d       = mode_cur;
      stall_cnt_d  = (mode_cur != MODE_RUN) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      hazard_err_d = hazard_err_q | bub_overrun;
   end

   // ---------------------------------------------------------------- regs
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q          <= MODE_RUN;
         stall_cnt_q     <= '0;
         bub_run_q       <= '0;
         redirect_pend_q <= 1'b0;
         hazard_err_q    <= 1'b0;
      end else begin
         mode_q          <= mode_d;
         stall_cnt_q     <= stall_cnt_d;
         bub_run_q       <= bub_run_d;
         redirect_pend_q <= redirect_pend_d;
         hazard_err_q    <= hazard_err_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign pc_wr       = ctrl.pc_wr;
   assign ifid_wr     = ctrl.ifid_wr;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_wr     = ctrl.idex_wr;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_wr    = ctrl.exmem_wr;
   assign memwb_flush = ctrl.memwb_flush;
   assign mode        = mode_q;
   assign stall_cnt   = stall_cnt_q;
   assign hazard_err  = hazard_err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//
// Directed bench for pipe_stall_ctrl. Two instances share the inputs: dut uses
// DELAY_SLOT=0 and dut_ds uses DELAY_SLOT=1. Inputs change on the falling edge;
// combinational outputs are sampled 1 ns later, registered outputs are sampled
// in the following cycle (after the rising edge in between).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

   logic clk = 1'b0;
   logic rst, branch_bubble, load_use, id_redirect, mem_wait;

   logic        pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush, exmem_wr, memwb_flush;
   logic [1:0]  mode;
   logic [31:0] stall_cnt;
   logic        hazard_err;

   logic        ds_pc_wr, ds_ifid_wr, ds_ifid_flush, ds_idex_wr, ds_idex_flush;
   logic        ds_exmem_wr, ds_memwb_flush;
   logic [1:0]  ds_mode;
   logic [31:0] ds_stall_cnt;
   logic        ds_hazard_err;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.DELAY_SLOT(0), .MAX_BUBBLE(2)) dut (
      .clk(clk), .rst(rst),
      .branch_bubble(branch_bubble), .load_use(load_use),
      .id_redirect(id_redirect), .mem_wait(mem_wait),
      .pc_wr(pc_wr), .ifid_wr(ifid_wr), .ifid_flush(ifid_flush),
      .idex_wr(idex_wr), .idex_flush(idex_flush), .exmem_wr(exmem_wr),
      .memwb_flush(memwb_flush), .mode(mode), .stall_cnt(stall_cnt),
      .hazard_err(hazard_err)
   );

   pipe_stall_ctrl #(.DELAY_SLOT(1), .MAX_BUBBLE(2)) dut_ds (
      .clk(clk), .rst(rst),
      .branch_bubble(branch_bubble), .load_use(load_use),
      .id_redirect(id_redirect), .mem_wait(mem_wait),
      .pc_wr(ds_pc_wr), .ifid_wr(ds_ifid_wr), .ifid_flush(ds_ifid_flush),
      .idex_wr(ds_idex_wr), .idex_flush(ds_idex_flush), .exmem_wr(ds_exmem_wr),
      .memwb_flush(ds_memwb_flush), .mode(ds_mode), .stall_cnt(ds_stall_cnt),
      .hazard_err(ds_hazard_err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge and settle.
   task automatic step(input logic r, input logic bb, input logic lu,
                       input logic rd, input logic mw);
      @(negedge clk);
      rst = r; branch_bubble = bb; load_use = lu; id_redirect = rd; mem_wait = mw;
      #1;
   endtask

   // Packs the seven combinational controls for one-shot comparison:
   // {pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush, exmem_wr, memwb_flush}
   function automatic logic [31:0] ctrl_vec();
      return {25'd0, pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush, exmem_wr, memwb_flush};
   endfunction

   localparam logic [31:0] CTRL_RUN    = 32'b1101010;
   localparam logic [31:0] CTRL_RUN_FL = 32'b1111010;
   localparam logic [31:0] CTRL_BUBBLE = 32'b0001110;
   localparam logic [31:0] CTRL_FREEZE = 32'b0000001;

   initial begin
      rst = 1'b1; branch_bubble = 1'b0; load_use = 1'b0; id_redirect = 1'b0; mem_wait = 1'b0;

      // ---------------- reset and reset-time combinational behaviour
      step(1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      check_val("rst_comb_bubble", ctrl_vec(), CTRL_BUBBLE);
      $display("txn reset: load_use during rst -> ctrl=%b", ctrl_vec());
      step(0, 0, 0, 0, 0);
      check_val("rst_mode", {30'd0, mode}, 32'd0);
      check_val("rst_stall_cnt", stall_cnt, 32'd0);
      check_val("rst_hazard_err", {31'd0, hazard_err}, 32'd0);
      check_val("run_ctrl", ctrl_vec(), CTRL_RUN);
      $display("txn run: mode=%0d cnt=%0d ctrl=%b", mode, stall_cnt, ctrl_vec());

      // ---------------- single load-use bubble
      step(0, 0, 1, 0, 0);
      check_val("lu_ctrl", ctrl_vec(), CTRL_BUBBLE);
      step(0, 0, 0, 0, 0);
      check_val("lu_mode", {30'd0, mode}, 32'd1);
      check_val("lu_stall_cnt", stall_cnt, 32'd1);
      $display("txn load_use: mode=%0d cnt=%0d", mode, stall_cnt);
      step(0, 0, 0, 0, 0);
      check_val("lu_mode_back_run", {30'd0, mode}, 32'd0);
      check_val("lu_cnt_hold", stall_cnt, 32'd1);

      // ---------------- freeze beats branch bubble
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 1);
         check_val($sformatf("frz_ctrl_%0d", i), ctrl_vec(), CTRL_FREEZE);
      end
      step(0, 0, 0, 0, 0);
      check_val("frz_mode", {30'd0, mode}, 32'd2);
      check_val("frz_stall_cnt", stall_cnt, 32'd3);
      check_val("frz_bub_run", {30'd0, dut.bub_run_q}, 32'd0);
      $display("txn freeze x3: mode=%0d cnt=%0d bub_run=%0d", mode, stall_cnt, dut.bub_run_q);
      // bub_run holds a nonzero value across a freeze, then clears on RUN
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      check_val("frz_bub_run_pre", {30'd0, dut.bub_run_q}, 32'd1);
      step(0, 0, 0, 0, 0);
      check_val("frz_bub_run_hold", {30'd0, dut.bub_run_q}, 32'd1);
      check_val("frz_cnt_5", stall_cnt, 32'd5);
      step(0, 0, 0, 0, 0);
      check_val("run_bub_run_clr", {30'd0, dut.bub_run_q}, 32'd0);

      // ---------------- redirect during freeze
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      check_val("rd_frz_ctrl", ctrl_vec(), CTRL_FREEZE);
      step(0, 0, 0, 0, 0);
      check_val("rd_pend_flush", ctrl_vec(), CTRL_RUN_FL);
      check_val("rd_pend_ds_flush", {31'd0, ds_ifid_flush}, 32'd0);
      $display("txn redirect-after-freeze: ifid_flush=%0d ds_ifid_flush=%0d", ifid_flush, ds_ifid_flush);
      step(0, 0, 0, 0, 0);
      check_val("rd_pend_once", {31'd0, ifid_flush}, 32'd0);
      // pending redirect survives a bubble
      step(0, 0, 0, 1, 1);
      step(0, 0, 1, 0, 0);
      check_val("rd_pend_bubble", ctrl_vec(), CTRL_BUBBLE);
      step(0, 0, 0, 0, 0);
      check_val("rd_pend_after_bub", {31'd0, ifid_flush}, 32'd1);
      step(0, 0, 0, 0, 0);
      check_val("rd_pend_after_bub_clr", {31'd0, ifid_flush}, 32'd0);
      // direct redirect in RUN
      step(0, 0, 0, 1, 0);
      check_val("rd_run_flush", {31'd0, ifid_flush}, 32'd1);
      check_val("rd_run_ds_flush", {31'd0, ds_ifid_flush}, 32'd0);
      // redirect in BUBBLE is ignored and not remembered
      step(0, 0, 1, 1, 0);
      check_val("rd_bub_ign", {31'd0, ifid_flush}, 32'd0);
      step(0, 0, 0, 0, 0);
      check_val("rd_bub_no_pend", {31'd0, ifid_flush}, 32'd0);
      $display("txn redirect-in-bubble: ifid_flush=%0d", ifid_flush);

      // ---------------- bubble overrun
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      check_val("ovr_err_1", {31'd0, hazard_err}, 32'd0);
      step(0, 1, 0, 0, 0);
      check_val("ovr_err_2", {31'd0, hazard_err}, 32'd0);
      step(0, 0, 0, 0, 0);
      check_val("ovr_err_3", {31'd0, hazard_err}, 32'd1);
      check_val("ovr_bub_run_sat", {30'd0, dut.bub_run_q}, 32'd3);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      check_val("ovr_err_sticky", {31'd0, hazard_err}, 32'd1);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_val("ovr_err_rst", {31'd0, hazard_err}, 32'd0);
      $display("txn bubble-overrun: hazard_err after rst=%0d", hazard_err);

      // ---------------- stall counter wrap
      @(negedge clk);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      load_use = 1'b1;
      #1;
      check_val("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
      step(0, 0, 0, 0, 0);
      check_val("wrap_zero", stall_cnt, 32'd0);
      $display("txn wrap: stall_cnt=0x%0h", stall_cnt);

      // ---------------- reset during freeze drops pending redirect
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1);
      check_val("rf_pend_set", {31'd0, dut.redirect_pend_q}, 32'd1);
      step(1, 0, 0, 0, 1);
      check_val("rf_rst_comb_freeze", ctrl_vec(), CTRL_FREEZE);
      step(0, 0, 0, 0, 0);
      check_val("rf_mode", {30'd0, mode}, 32'd0);
      check_val("rf_stall_cnt", stall_cnt, 32'd0);
      check_val("rf_no_flush", {31'd0, ifid_flush}, 32'd0);
      $display("txn rst-in-freeze: mode=%0d cnt=%0d ifid_flush=%0d", mode, stall_cnt, ifid_flush);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
